pdm_cic_decimator: RTL

PDM_CIC_DECIMATOR -- requirements
Module: pdm_cic_decimator

---
 rtl/pdm_cic_decimator.sv | 138 +++++++++++++
 1 files changed

// File: rtl/pdm_cic_decimator.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pdm_cic_decimator                                            |
// | Description : PDM microphone clock generator and 4th-order CIC decimator.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module pdm_cic_decimator #(
  parameter int CLK_DIV   = 4,
  parameter int DECIM     = 64,
  parameter int OUT_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        en,
  output logic                        pdm_clk,
  input  logic                        pdm_data,
  output logic signed [OUT_WIDTH-1:0] pcm_data,
  output logic                        pcm_valid
);

  localparam int ACC_WIDTH = 4 * $clog2(DECIM) + 1;
  localparam int SHIFT     = ACC_WIDTH - OUT_WIDTH;
  localparam int DIV_W     = $clog2(CLK_DIV);
  localparam int DEC_W     = $clog2(DECIM);

  localparam logic signed [ACC_WIDTH-1:0] c_plus_one  = {{(ACC_WIDTH-1){1'b0}}, 1'b1};
  localparam logic signed [ACC_WIDTH-1:0] c_minus_one = '1;
  localparam logic signed [ACC_WIDTH-1:0] c_acc_min   = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] c_out_max   = {{(SHIFT+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] c_out_min   = ~c_out_max;

  logic [DIV_W-1:0]            r_div_cnt;
  logic                        r_sync1, r_sync2;
  logic [DEC_W-1:0]            r_dec_cnt;
  logic [3:0]                  r_hist;
  logic signed [ACC_WIDTH-1:0] r_integ [4];
  logic signed [ACC_WIDTH-1:0] r_dly   [4];

  logic                        w_div_tc, w_sample, w_decim, w_pos_fs;
  logic signed [ACC_WIDTH-1:0] w_x, w_comb1, w_comb2, w_comb3, w_comb4, w_scaled;
  logic signed [OUT_WIDTH-1:0] w_sat;

  assign w_div_tc = (r_div_cnt == DIV_W'(CLK_DIV - 1));
  assign w_sample = en && w_div_tc && !pdm_clk;
  assign w_decim  = w_sample && (r_dec_cnt == DEC_W'(DECIM - 1));
  assign w_x      = r_sync2 ? c_plus_one : c_minus_one;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      pdm_clk   <= 1'b0;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
    end else if (!en) begin
      r_div_cnt <= '0;
      pdm_clk   <= 1'b0;
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
    end else begin
      r_sync1 <= pdm_data;
      r_sync2 <= r_sync1;
      if (w_div_tc) begin
        r_div_cnt <= '0;
        pdm_clk   <= ~pdm_clk;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end
    end
  end

  assign w_comb1 = r_integ[3] - r_dly[0];
  assign w_comb2 = w_comb1 - r_dly[1];
  assign w_comb3 = w_comb2 - r_dly[2];
  assign w_comb4 = w_comb3 - r_dly[3];

  // Integrators use pre-update values, giving a one-sample skew per stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_cnt <= '0;
      r_hist    <= '0;
      for (int k = 0; k < 4; k++) begin
        r_integ[k] <= '0;
        r_dly[k]   <= '0;
      end
    end else if (!en) begin
      r_dec_cnt <= '0;
      r_hist    <= '0;
      for (int k = 0; k < 4; k++) begin
        r_integ[k] <= '0;
        r_dly[k]   <= '0;
      end
    end else if (w_sample) begin
      r_hist     <= {r_hist[2:0], r_sync2};
      r_integ[0] <= r_integ[0] + w_x;
      for (int k = 1; k < 4; k++) begin
        r_integ[k] <= r_integ[k] + r_integ[k-1];
      end
      if (w_decim) begin
        r_dec_cnt <= '0;
        r_dly[0]  <= r_integ[3];
        r_dly[1]  <= w_comb1;
        r_dly[2]  <= w_comb2;
        r_dly[3]  <= w_comb3;
      end else begin
        r_dec_cnt <= r_dec_cnt + DEC_W'(1);
      end
    end
  end

  // Full-scale +DECIM^4 aliases onto the most negative code; the newest sample
  // inside the comb window (r_hist[3]) tells the two apart, since either
  // extreme needs every sample in the window to share that sign.
  always_comb begin
    w_scaled = w_comb4 >>> SHIFT;
    w_pos_fs = r_hist[3] && (w_comb4 == c_acc_min);
    w_sat    = w_scaled[OUT_WIDTH-1:0];
    if (w_pos_fs || (w_scaled > c_out_max)) begin
      w_sat = c_out_max[OUT_WIDTH-1:0];
    end else if (w_scaled < c_out_min) begin
      w_sat = c_out_min[OUT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcm_data  <= '0;
      pcm_valid <= 1'b0;
    end else begin
      pcm_valid <= w_decim;
      if (w_decim) begin
        pcm_data <= w_sat;
      end
    end
  end

endmodule
`default_nettype wire
